// File: rtl/shift_ctrl.sv
// ---------------------------------------------------------------------------
// shift_ctrl
// Moves the contents of a source shift register X into a destination shift
// register Y, one bit per clock, LSB first.  A transfer is started from IDLE,
// runs exactly WIDTH shifts in SHIFT, then pulses done for one cycle in DONE.
// In mode 0 the bit leaving X is fed back into X's MSB, so X ends unchanged;
// in mode 1 zeros are shifted in, so X ends cleared.
//
// Optional feature macro: SHIFT_CTRL_ABORT_EN adds an abort input that
// cancels a transfer in SHIFT, leaving partial X/Y/count values.
//
// Ports:
//   clock    in   single clock, rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   transfer request, honoured only in IDLE
//   abort    in   (SHIFT_CTRL_ABORT_EN only) cancel transfer in SHIFT
//   mode     in   0 = X recirculates, 1 = X zero-fills; sampled with start
//   load_val in   value loaded into X when a transfer is accepted
//   X        out  source shift register
//   Y        out  destination shift register
//   shift_en out  high in every cycle a shift occurs (state SHIFT)
//   busy     out  high whenever state is not IDLE
//   done     out  one-cycle completion pulse (state DONE)
//   count    out  shifts completed in the current transfer, 0..WIDTH
// ---------------------------------------------------------------------------
module shift_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
`ifdef SHIFT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [4:0]       count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r;
    logic       mode_q_r;
    logic [4:0] count_inc_s;
    logic       last_shift_s;
    logic       abort_s;

    assign count_inc_s  = count + 5'd1;
    // The shift that brings count up to WIDTH is the final one.
    assign last_shift_s = (count_inc_s == 5'(WIDTH));

`ifdef SHIFT_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // FSM, datapath registers and registered status outputs.
    // Status outputs are assigned together with the next state so that they
    // always decode the state register exactly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            mode_q_r <= 1'b0;
            X        <= '0;
            Y        <= '0;
            count    <= 5'd0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        X        <= load_val;
                        mode_q_r <= mode;
                        count    <= 5'd0;
                        state_r  <= SHIFT;
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        shift_en <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort_s) begin
                        // Partial X/Y/count are kept for inspection.
                        state_r  <= IDLE;
                        shift_en <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        Y     <= {X[0], Y[WIDTH-1:1]};
                        X     <= {(mode_q_r ? 1'b0 : X[0]), X[WIDTH-1:1]};
                        count <= count_inc_s;
                        busy  <= 1'b1;
                        if (last_shift_s) begin
                            state_r  <= DONE;
                            shift_en <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state_r  <= SHIFT;
                            shift_en <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_ctrl
// Directed bench for shift_ctrl (WIDTH=4): a per-cycle vector table for the
// reset and basic mode-0 transfer, then hand-written sequences for zero-fill,
// ignored start/mode during a transfer, start held through DONE, reset in
// mid-transfer and (when SHIFT_CTRL_ABORT_EN is defined) abort.
// ---------------------------------------------------------------------------
module tb_shift_ctrl;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       mode;
    logic [3:0] load_val;
    logic [3:0] X;
    logic [3:0] Y;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [4:0] count;
`ifdef SHIFT_CTRL_ABORT_EN
    logic       abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shift_ctrl #(.WIDTH(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
`ifdef SHIFT_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .mode     (mode),
        .load_val (load_val),
        .X        (X),
        .Y        (Y),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rn;
        logic       st;
        logic       md;
        logic [3:0] lv;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [4:0] ec;
        logic       es;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs [9];

    // Apply current inputs at the next rising edge, sample 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {16'd0, X, Y, count, shift_en, busy, done};
    endfunction

    initial begin
        logic [24:0] cseq;
        int          dn;

        reset_n  = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        load_val = 4'd0;
`ifdef SHIFT_CTRL_ABORT_EN
        abort    = 1'b0;
`endif

        //             rn    st    md    lv       X        Y        cnt   se    b     d
        vecs[0] = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 4'b1011, 4'b1011, 4'b0000, 5'd0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1101, 4'b1000, 5'd1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1110, 4'b1100, 5'd2, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b0110, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1011, 4'b1011, 5'd4, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1011, 4'b1011, 5'd4, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 4'b0101, 4'b1011, 4'b1011, 5'd4, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            reset_n  = vecs[i].rn;
            start    = vecs[i].st;
            mode     = vecs[i].md;
            load_val = vecs[i].lv;
            step();
            check($sformatf("vec%0d", i), outs(),
                  {16'd0, vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].es, vecs[i].eb, vecs[i].ed});
        end

        // Zero-fill transfer: X cleared, Y gets the value, one done pulse.
        start = 1'b1; mode = 1'b1; load_val = 4'b1101;
        step();
        start = 1'b0; mode = 1'b0; load_val = 4'b0000;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dn++;
        end
        check("mode1_final_xy", {24'd0, X, Y}, {24'd0, 4'b0000, 4'b1101});
        check("mode1_done_pulses", dn, 32'd1);
        check("mode1_idle", {30'd0, busy, count == 5'd4}, {30'd0, 1'b0, 1'b1});

        // Start/mode/load_val changes mid-transfer are ignored.
        start = 1'b1; mode = 1'b0; load_val = 4'b1011;
        step();
        cseq[24:20] = count;
        for (int i = 1; i < 5; i++) begin
            if (count == 5'd2) begin
                start = 1'b1; mode = 1'b1; load_val = 4'b0110;
            end else begin
                start = 1'b0; mode = 1'b0; load_val = 4'b0000;
            end
            step();
            cseq[24 - 5*i -: 5] = count;
        end
        check("ignore_count_seq", {7'd0, cseq}, {7'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4});
        check("ignore_final", outs(), {16'd0, 4'b1011, 4'b1011, 5'd4, 1'b0, 1'b1, 1'b1});

        // Start held through DONE: first edge returns to IDLE, next loads.
        start = 1'b1; load_val = 4'b0101;
        step();
        check("held_start_idle", {30'd0, busy, done}, 32'd0);
        check("held_start_x_kept", {28'd0, X}, {28'd0, 4'b1011});
        step();
        start = 1'b0;
        check("held_start_load", {23'd0, X, busy, shift_en, count}, {23'd0, 4'b0101, 1'b1, 1'b1, 5'd0});
        for (int i = 0; i < 5; i++) step();
        check("held_start_final", outs(), {16'd0, 4'b0101, 4'b0101, 5'd4, 1'b0, 1'b0, 1'b0});

        // Reset in mid-transfer abandons it, no done pulse.
        start = 1'b1; load_val = 4'b1011;
        step();
        start = 1'b0;
        step();
        step();
        check("rst_mid_pre", {27'd0, count}, {27'd0, 5'd2});
        reset_n = 1'b0; start = 1'b1;
        step();
        check("rst_mid_state", outs(), 32'd0);
        reset_n = 1'b1; start = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) dn++;
        end
        check("rst_mid_no_done", dn, 32'd0);

`ifdef SHIFT_CTRL_ABORT_EN
        // Abort after two shifts keeps partial values, then a normal run.
        start = 1'b1; mode = 1'b0; load_val = 4'b1011;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", outs(), {16'd0, 4'b1110, 4'b1100, 5'd2, 1'b0, 1'b0, 1'b0});
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) dn++;
        end
        check("abort_no_done", dn, 32'd0);
        start = 1'b1; load_val = 4'b0011;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_rerun", outs(), {16'd0, 4'b0011, 4'b0011, 5'd4, 1'b0, 1'b1, 1'b1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
